// File: rtl/nmr_pkg.sv
// Shared definitions for the NMR spectrometer transmit/receive phase path.
package nmr_pkg;

  localparam int N_BITS_DEF = 16;
  localparam int N_PARA_DEF = 4;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2
  } cyc_state_t;

endpackage

// File: rtl/qpsk_lane_shift.sv
// One sample lane: selects I or Q and optionally negates it to realise a
// 0/90/180/270 degree shift. Negation saturates so the most negative code maps to the maximum.
module qpsk_lane_shift
  import nmr_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic [N_BITS-1:0] i,
  input  logic [N_BITS-1:0] q,
  input  logic [1:0]        phase,
  output logic [N_BITS-1:0] y
);

  localparam logic [N_BITS-1:0] MIN_VAL = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [N_BITS-1:0] MAX_VAL = {1'b0, {(N_BITS-1){1'b1}}};

  function automatic logic [N_BITS-1:0] sat_neg(input logic [N_BITS-1:0] x);
    return (x == MIN_VAL) ? MAX_VAL : -x;
  endfunction

  always_comb begin
    case (phase)
      PH_0:    y = i;
      PH_90:   y = q;
      PH_180:  y = sat_neg(i);
      default: y = sat_neg(q);
    endcase
  end

endmodule

// File: rtl/tx_phase_cycler.sv
// Phase-cycling stage: steps through a table of (TX, RX) phase pairs on each
// scan start, shifts the parallel DDS stream and gates it with the RF pulse.
module tx_phase_cycler
  import nmr_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int N_PARA = N_PARA_DEF,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BITS*N_PARA-1:0] dds_i,
  input  logic [N_BITS*N_PARA-1:0] dds_q,
  input  logic                     cfg_we,
  input  logic [PTR_W-1:0]         cfg_addr,
  input  logic [1:0]               cfg_tx_phase,
  input  logic [1:0]               cfg_rx_phase,
  input  logic                     cfg_len_we,
  input  logic [PTR_W:0]           cfg_len,
  input  logic                     scan_start,
  input  logic                     pulse_en,
  output logic [N_BITS*N_PARA-1:0] tx_out,
  output logic                     tx_valid,
  output logic [1:0]               rx_phase,
  output logic [PTR_W-1:0]         cycle_idx,
  output logic                     cycle_wrap,
  output logic                     cfg_err
);

  localparam logic [PTR_W:0] LEN_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LEN_ONE = (PTR_W+1)'(1);

  cyc_state_t state_q, state_d;
  logic       scan_acc, scan_rej;

  logic [1:0]       tx_tab [DEPTH];
  logic [1:0]       rx_tab [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W:0]   len_q, len_new, ptr_inc;
  logic             last_entry;
  logic [1:0]       act_tx, eff_tx;

  logic [N_BITS*N_PARA-1:0] shift_w, s1_data;
  logic                     s1_pen;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    scan_acc = 1'b0;
    scan_rej = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          scan_acc = 1'b1;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        scan_acc = scan_start;
        if (pulse_en) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        scan_rej = scan_start;
        if (!pulse_en) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the table is a small flop array, so resetting it is cheap and keeps it deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        tx_tab[k] <= PH_0;
        rx_tab[k] <= PH_0;
      end
    end else if (cfg_we) begin
      tx_tab[cfg_addr] <= cfg_tx_phase;
      rx_tab[cfg_addr] <= cfg_rx_phase;
    end
  end

  assign len_new    = (cfg_len == '0) ? LEN_ONE : ((cfg_len > LEN_MAX) ? LEN_MAX : cfg_len);
  assign ptr_inc    = {1'b0, ptr_q} + LEN_ONE;
  assign last_entry = (ptr_inc == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= LEN_ONE;
      ptr_q      <= '0;
      act_tx     <= PH_0;
      rx_phase   <= PH_0;
      cycle_idx  <= '0;
      cycle_wrap <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cycle_wrap <= scan_acc && last_entry;
      if (scan_rej) cfg_err <= 1'b1;
      if (scan_acc) begin
        act_tx    <= tx_tab[ptr_q];
        rx_phase  <= rx_tab[ptr_q];
        cycle_idx <= ptr_q;
        ptr_q     <= last_entry ? '0 : ptr_inc[PTR_W-1:0];
      end
      // A length write restarts the cycle even when it coincides with a scan.
      if (cfg_len_we) begin
        len_q <= len_new;
        ptr_q <= '0;
      end
    end
  end

  // The entry being loaded is forwarded so data in the scan cycle already carries the new phase.
  assign eff_tx = scan_acc ? tx_tab[ptr_q] : act_tx;

  for (genvar g = 0; g < N_PARA; g++) begin : g_lane
    qpsk_lane_shift #(.N_BITS(N_BITS)) u_lane (
      .i     (dds_i[g*N_BITS +: N_BITS]),
      .q     (dds_q[g*N_BITS +: N_BITS]),
      .phase (eff_tx),
      .y     (shift_w[g*N_BITS +: N_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_pen   <= 1'b0;
      tx_out   <= '0;
      tx_valid <= 1'b0;
    end else begin
      s1_data  <= shift_w;
      s1_pen   <= pulse_en && (state_q != ST_IDLE);
      tx_valid <= s1_pen;
      tx_out   <= s1_pen ? s1_data : '0;
    end
  end

endmodule

// File: tb/tb_tx_phase_cycler.sv
// Directed self-checking bench for tx_phase_cycler with hand-computed expectations.
module tb_tx_phase_cycler;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] dds_i, dds_q;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_tx_phase, cfg_rx_phase;
  logic        cfg_len_we;
  logic [4:0]  cfg_len;
  logic        scan_start, pulse_en;
  logic [63:0] tx_out;
  logic        tx_valid;
  logic [1:0]  rx_phase;
  logic [3:0]  cycle_idx;
  logic        cycle_wrap, cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] SAT_I  = 64'h8000_7FFF_0001_0000;
  localparam logic [63:0] SAT_Q  = 64'h8000_1234_FFFF_0002;
  localparam logic [63:0] SAT_P1 = 64'h8000_1234_FFFF_0002;
  localparam logic [63:0] SAT_P2 = 64'h7FFF_8001_FFFF_0000;
  localparam logic [63:0] SAT_P3 = 64'h7FFF_EDCC_0001_FFFE;

  tx_phase_cycler dut (
    .clk          (clk),
    .rst          (rst),
    .dds_i        (dds_i),
    .dds_q        (dds_q),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_tx_phase (cfg_tx_phase),
    .cfg_rx_phase (cfg_rx_phase),
    .cfg_len_we   (cfg_len_we),
    .cfg_len      (cfg_len),
    .scan_start   (scan_start),
    .pulse_en     (pulse_en),
    .tx_out       (tx_out),
    .tx_valid     (tx_valid),
    .rx_phase     (rx_phase),
    .cycle_idx    (cycle_idx),
    .cycle_wrap   (cycle_wrap),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_scan(input string tag, input int exp_idx, input int exp_rx, input bit exp_wrap);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    check({tag, " idx"},  64'(cycle_idx),  64'(exp_idx));
    check({tag, " rx"},   64'(rx_phase),   64'(exp_rx));
    check({tag, " wrap"}, 64'(cycle_wrap), 64'(exp_wrap));
  endtask

  // pulse_en high for n cycles; tx_valid/tx_out follow two cycles later.
  task automatic pulse_run(input string tag, input int n, input logic [63:0] exp_lanes);
    for (int k = 0; k <= n + 1; k++) begin
      pulse_en = (k < n);
      step();
      if (k >= 1 && k <= n) begin
        check({tag, " valid"}, 64'(tx_valid), 64'd1);
        check({tag, " data"},  tx_out,        exp_lanes);
      end else begin
        check({tag, " valid"}, 64'(tx_valid), 64'd0);
        check({tag, " data"},  tx_out,        64'd0);
      end
    end
    pulse_en = 1'b0;
  endtask

  task automatic write_entry(input int addr, input int txp, input int rxp);
    cfg_we       = 1'b1;
    cfg_addr     = 4'(addr);
    cfg_tx_phase = 2'(txp);
    cfg_rx_phase = 2'(rxp);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic write_len(input int len);
    cfg_len_we = 1'b1;
    cfg_len    = 5'(len);
    step();
    cfg_len_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dds_i = '0; dds_q = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_tx_phase = '0; cfg_rx_phase = '0; cfg_len_we = 1'b0; cfg_len = '0;
    scan_start = 1'b0; pulse_en = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst tx_out", tx_out, 64'd0);
    check("rst tx_valid", 64'(tx_valid), 64'd0);
    check("rst rx_phase", 64'(rx_phase), 64'd0);
    check("rst cycle_idx", 64'(cycle_idx), 64'd0);
    check("rst cycle_wrap", 64'(cycle_wrap), 64'd0);
    check("rst cfg_err", 64'(cfg_err), 64'd0);

    // Pulse while still IDLE must never reach the DAC.
    dds_i = {4{16'h1000}};
    dds_q = {4{16'h0800}};
    pulse_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle valid", 64'(tx_valid), 64'd0);
      check("idle data", tx_out, 64'd0);
    end
    pulse_en = 1'b0;
    step();

    // Zero table, default length 1: every scan wraps.
    do_scan("scan0", 0, 0, 1'b1);
    pulse_run("zero tbl", 4, {4{16'h1000}});
    check("wrap drop", 64'(cycle_wrap), 64'd0);

    write_entry(0, 1, 3);
    write_entry(1, 2, 0);
    write_entry(2, 3, 1);
    write_entry(3, 0, 2);
    write_len(4);

    do_scan("scan1", 0, 3, 1'b0);
    pulse_run("ph90", 2, {4{16'h0800}});
    do_scan("scan2", 1, 0, 1'b0);
    pulse_run("ph180", 2, {4{16'hF000}});
    do_scan("scan3", 2, 1, 1'b0);
    pulse_run("ph270", 2, {4{16'hF800}});
    do_scan("scan4", 3, 2, 1'b1);
    pulse_run("ph0", 2, {4{16'h1000}});

    // Distinct lanes including the most negative code.
    dds_i = SAT_I;
    dds_q = SAT_Q;
    do_scan("scan5", 0, 3, 1'b0);
    pulse_run("sat p1", 2, SAT_P1);
    do_scan("scan6", 1, 0, 1'b0);
    pulse_run("sat p2", 2, SAT_P2);
    do_scan("scan7", 2, 1, 1'b0);
    pulse_run("sat p3", 2, SAT_P3);

    // scan_start inside a pulse is rejected and the pulse is undisturbed.
    pulse_en = 1'b1;
    step(); step();
    check("pre rej valid", 64'(tx_valid), 64'd1);
    check("pre rej data", tx_out, SAT_P3);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    check("rej err", 64'(cfg_err), 64'd1);
    check("rej idx", 64'(cycle_idx), 64'd2);
    check("rej rx", 64'(rx_phase), 64'd1);
    check("rej wrap", 64'(cycle_wrap), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check("rej valid", 64'(tx_valid), 64'd1);
      check("rej data", tx_out, SAT_P3);
      step();
    end
    pulse_en = 1'b0;
    step(); step(); step();
    check("rej drained", 64'(tx_valid), 64'd0);
    do_scan("scan8", 3, 2, 1'b1);
    check("err sticky", 64'(cfg_err), 64'd1);

    // Length 0 behaves as length 1.
    write_len(0);
    do_scan("len0 a", 0, 3, 1'b1);
    do_scan("len0 b", 0, 3, 1'b1);

    // Write to entry 0 in the same cycle it is loaded: old value wins.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_tx_phase = 2'd2; cfg_rx_phase = 2'd1;
    scan_start = 1'b1;
    step();
    cfg_we = 1'b0; scan_start = 1'b0;
    check("raw idx", 64'(cycle_idx), 64'd0);
    check("raw rx old", 64'(rx_phase), 64'd3);
    pulse_run("raw old", 2, SAT_P1);
    do_scan("raw next", 0, 1, 1'b1);
    pulse_run("raw new", 2, SAT_P2);

    // Reset during a pulse clears the output on the very next cycle.
    pulse_en = 1'b1;
    step(); step(); step();
    check("mid valid", 64'(tx_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rst data", tx_out, 64'd0);
    check("mid rst valid", 64'(tx_valid), 64'd0);
    check("mid rst idx", 64'(cycle_idx), 64'd0);
    check("mid rst rx", 64'(rx_phase), 64'd0);
    check("mid rst err", 64'(cfg_err), 64'd0);
    step(); step();
    check("post rst idle", 64'(tx_valid), 64'd0);
    check("post rst data", tx_out, 64'd0);
    pulse_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_phase_cycler.md
# tx_phase_cycler

Transmit-side phase-cycling stage of the NMR spectrometer. Holds a programmable table of up to 16 (TX phase, RX phase) pairs. On each scan start it steps to the next table entry. It applies the selected 0/90/180/270° shift to the 4-sample-parallel DDS I/Q stream and gates the result with the RF pulse enable to form the DAC drive. It also presents the matching receiver phase to the receive-side QPSK demodulation stage, so the TX and RX phase cycles stay locked.

## Interface
Parameters:
- N_BITS, 16, bits per sample
- N_PARA, 4, parallel samples per 64-bit word
- DEPTH, 16, phase-table entries (power of 2)
- PTR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  system clock; one clock for the whole block
- rst  in  1  reset, synchronous, active-high
- dds_i  in  64  4 × signed 16-bit DDS cosine samples, lane 0 = bits [15:0]
- dds_q  in  64  4 × signed 16-bit DDS sine samples
- cfg_we  in  1  write the table entry at cfg_addr
- cfg_addr  in  PTR_W  table index
- cfg_tx_phase  in  2  TX phase code: 0=0°, 1=90°, 2=180°, 3=270°
- cfg_rx_phase  in  2  RX phase code, same encoding
- cfg_len_we  in  1  write the cycle length
- cfg_len  in  PTR_W+1  cycle length 1..16; a value of 0 is stored as 1
- scan_start  in  1  single-cycle pulse; advances to the next entry
- pulse_en  in  1  RF pulse gate
- tx_out  out  64  phase-shifted, gated TX samples
- tx_valid  out  1  tx_out carries pulse data
- rx_phase  out  2  active RX phase code for the receive demodulator
- cycle_idx  out  PTR_W  index of the active entry
- cycle_wrap  out  1  1-cycle pulse when the active entry is the last one in the cycle
- cfg_err  out  1  sticky flag: a scan_start was rejected

## Operation
- Phase map, applied per lane: code 0 → i; 1 → q; 2 → −i; 3 → −q.
  - Negation saturates: −(−32768) = 32767.
- FSM states:
  - IDLE: entered on reset. tx_out is forced to 0 and pulse_en is ignored. scan_start → ARMED.
  - ARMED: pulse_en=1 → PULSE. scan_start → ARMED, loading the next entry.
  - PULSE: pulse_en=0 → ARMED. scan_start is ignored and sets cfg_err.
- Accepted scan_start:
  - Load table[ptr] into the active TX and RX phase registers; cycle_idx ← ptr.
  - ptr ← (ptr+1 == len) ? 0 : ptr+1.
  - cycle_wrap = 1 for one cycle when the loaded index equals len−1.
- The active phase changes only on an accepted scan_start. It never changes mid-pulse.
- cfg_we and scan_start in the same cycle: scan_start reads the old entry (read-before-write).
- cfg_len_we: sets ptr ← 0; the active registers are unchanged. If it coincides with scan_start, scan_start uses the old ptr, then ptr ← 0.
- If ptr ≥ new len, the next scan uses 0, because cfg_len_we already reset ptr.
- cfg_err is cleared only by rst.
- rst mid-pulse: returns to IDLE, the pipeline is flushed, and tx_out is 0 the next cycle.

## Timing
- Reset values:
  - tx_out = 0, tx_valid = 0, rx_phase = 0, cycle_idx = 0, cycle_wrap = 0, cfg_err = 0.
  - ptr = 0, len = 1, all table entries = 0.
- Data latency is 2 cycles from dds_i/dds_q/pulse_en to tx_out/tx_valid.
  - Stage 1: per-lane select and saturating negate, registered.
  - Stage 2: gate with pulse_en delayed 1 cycle, qualified by the FSM being out of IDLE.
- tx_valid = gated pulse_en delayed 2 cycles. tx_out = 0 whenever tx_valid = 0.
- rx_phase, cycle_idx and cycle_wrap update 1 cycle after an accepted scan_start.
- The new TX phase appears on tx_out 2 cycles after the scan_start cycle.
- pulse_en asserted in the cycle after scan_start is legal.

## Structure
- Shared package (nmr_pkg): phase-code localparams (PH_0/90/180/270), N_BITS/N_PARA defaults, and the FSM state encoding.
- Sub-module qpsk_lane_shift: one 16-bit lane, combinational select and saturating negate. Instantiated N_PARA times in a generate loop.
- The table is a register array with reset; no RAM.

## Test plan
- Reset, then scan_start with an all-zero table; dds_i lanes = 0x1000, dds_q = 0x0800, pulse_en = 1 for 4 cycles → tx_out lanes = 0x1000, tx_valid high for 4 cycles starting 2 cycles after pulse_en; rx_phase = 0.
- Load entries {(1,3),(2,0),(3,1),(0,2)}, len = 4, four scans each with a pulse → tx lanes 0x0800, 0xF000, 0xF800, 0x1000; rx_phase 3,0,1,2; cycle_wrap on the 4th scan; the 5th scan gives cycle_idx = 0.
- Saturation: dds_i lane = 0x8000, phase 2 → 0x7FFF; dds_q = 0x8000, phase 3 → 0x7FFF.
- scan_start during PULSE → cfg_err = 1, cycle_idx and tx phase unchanged, tx_out continues uninterrupted.
- pulse_en before the first scan_start (IDLE) → tx_out = 0, tx_valid = 0. cfg_len = 0 → behaves as len 1, with cycle_wrap on every scan.
- cfg_we to entry 0 in the same cycle as a scan_start that loads entry 0 → old phase used; the next pass uses the new phase. rst mid-pulse → tx_out = 0 the next cycle.
